// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract unit that runs one operand pair through a 4-bit carry-lookahead slice, one nibble per clock.
// Optional `define ZERO_FLAG_EN adds a registered all-zero result flag output (zero).
module nibble_serial_addsub #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow
`ifdef ZERO_FLAG_EN
    ,output logic                  zero
`endif
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
`ifdef ZERO_FLAG_EN
    logic            zero_q, zero_d;
`endif

    logic [IW+1:0]   sh;
    logic [3:0]      a_nib, b_nib, p, g, sum;
    logic [4:0]      c;
    logic [W-1:0]    acc_ins;

    // 4-bit carry-lookahead slice on the current nibble; b is inverted and carry seeded with mode for subtract
    always_comb begin
        sh    = {idx_q, 2'b00};
        a_nib = 4'(a_q >> sh);
        b_nib = 4'(b_q >> sh) ^ {4{mode_q}};
        p     = a_nib ^ b_nib;
        g     = a_nib & b_nib;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum   = p ^ c[3:0];
        acc_ins = (acc_q & ~(W'(4'hF) << sh)) | (W'(sum) << sh);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    carry_d = mode;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_ins;
                carry_d = c[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NIBBLES - 1)) begin
                    result_d = acc_ins;
                    cout_d   = c[4];
                    ovf_d    = c[3] ^ c[4];
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = IDLE;
`ifdef ZERO_FLAG_EN
                    zero_d   = (acc_ins == '0);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
`ifdef ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomised bench for nibble_serial_addsub with a cycle-level arithmetic reference model and directed corner cases.
module tb_nibble_serial_addsub;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;
`ifdef ZERO_FLAG_EN
    logic         zero;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
`ifdef ZERO_FLAG_EN
        ,.zero    (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {overflow, cout, result} from plain integer arithmetic.
    function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        longint ux, uy, sx, sy, ur, sr, mod;
        logic c, v;
        mod = longint'(1) << W;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = x[W-1] ? ux - mod : ux;
        sy  = y[W-1] ? uy - mod : uy;
        ur  = m ? ux + (mod - 1 - uy) + 1 : ux + uy;
        sr  = m ? sx - sy : sx + sy;
        c   = ((ur / mod) % 2) == 1;
        v   = (sr > (mod / 2) - 1) || (sr < -(mod / 2));
        return {v, c, W'(ur % mod)};
    endfunction

    int           m_rem  = 0;
    logic [W+1:0] m_pend = '0;
    logic [W-1:0] m_res  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic         m_done = 1'b0;
    logic         m_zero = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_done <= 1'b0;
            m_zero <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_pend <= calc(a, b, mode);
                    m_rem  <= NIBBLES;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend[W-1:0];
                    m_cout <= m_pend[W];
                    m_ovf  <= m_pend[W+1];
                    m_zero <= (m_pend[W-1:0] == '0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("result", 64'(result), 64'(m_res));
            chk("cout", 64'(cout), 64'(m_cout));
            chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef ZERO_FLAG_EN
            chk("zero", 64'(zero), 64'(m_zero));
`endif
        end
    end

    // Must be entered while the DUT is idle; start is sampled on the next rising edge.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                         input logic [W+1:0] exp, input string nm);
        int n, nb;
        a = x; b = y; mode = m; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        mode = 1'($urandom);
        n = 0; nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end while (!done && n < 40);
        chk({nm, "_latency"}, 64'(n), 64'(NIBBLES + 1));
        chk({nm, "_busycycles"}, 64'(nb), 64'(NIBBLES));
        chk({nm, "_result"}, 64'(result), 64'(exp[W-1:0]));
        chk({nm, "_cout"}, 64'(cout), 64'(exp[W]));
        chk({nm, "_ovf"}, 64'(overflow), 64'(exp[W+1]));
    endtask

    initial begin
        int n;
        logic [W+1:0] v;

        v = calc(16'h7FFF, 16'h0001, 1'b0); chk("model_add_ovf", 64'(v), 64'h28000);
        v = calc(16'hFFFF, 16'h0001, 1'b0); chk("model_add_wrap", 64'(v), 64'h10000);
        v = calc(16'h8000, 16'h0001, 1'b1); chk("model_sub_ovf", 64'(v), 64'h37FFF);
        v = calc(16'h0000, 16'h0001, 1'b1); chk("model_sub_borrow", 64'(v), 64'h0FFFF);

        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({cout, overflow}), 64'd0);

        do_op(16'h0000, 16'h0001, 1'b0, 18'h00001, "add_basic");
        do_op(16'h000A, 16'h0001, 1'b1, 18'h10009, "sub_basic");
        do_op(16'h0000, 16'h0001, 1'b1, 18'h0FFFF, "sub_borrow");
        do_op(16'h7FFF, 16'h0001, 1'b0, 18'h28000, "add_ovf");
        do_op(16'hFFFF, 16'h0001, 1'b0, 18'h10000, "add_wrap");
        do_op(16'h8000, 16'h0001, 1'b1, 18'h37FFF, "sub_ovf");

        // start during RUN ignored, then back-to-back start in the done cycle
        a = 16'h1111; b = 16'h2222; mode = 1'b0; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(posedge clk); #2; a = 16'hFFFF; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        chk("ignore_done_seen", 64'(done), 64'd1);
        chk("ignore_result", 64'(result), 64'h3333);
        do_op(16'h0003, 16'h0004, 1'b0, 18'h00007, "b2b");

        // reset in the second RUN cycle abandons the operation
        a = 16'h1234; b = 16'h1111; mode = 1'b0; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_flags", 64'({done, cout, overflow}), 64'd0);
        n = 0;
        repeat (8) begin @(negedge clk); if (done) n++; end
        chk("midrst_no_done", 64'(n), 64'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 18'h02345, "after_rst");

`ifdef ZERO_FLAG_EN
        do_op(16'h1234, 16'h1234, 1'b1, 18'h10000, "zero_sub");
        chk("zero_set", 64'(zero), 64'd1);
        do_op(16'h0001, 16'h0000, 1'b0, 18'h00001, "zero_clr");
        chk("zero_clear", 64'(zero), 64'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            mode  = 1'($urandom);
            rst   = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk); #2;
        start = 1'b0;
        rst   = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle wide add/subtract unit built around a 4-bit carry-lookahead add/sub slice.
- Accepts a wide operand pair plus a mode bit, then feeds the slice one nibble per clock, LSB nibble first, with the inter-nibble carry held in a register.
- Collects the sum nibbles, then presents the full-width result with carry and signed-overflow flags and a one-cycle done pulse.
- Sits directly around the 4-bit add/sub stage: it is both the operand feeder and the result consumer.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  request a new operation; sampled only in IDLE.
mode  in  1  0 = add (a+b), 1 = subtract (a-b).
a  in  W  first operand (minuend when mode=1).
b  in  W  second operand (subtrahend when mode=1).
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
result  out  W  sum/difference modulo 2^W.
cout  out  1  carry out of MSB; on subtract, 1 = no borrow.
overflow  out  1  two's-complement signed overflow of the W-bit operation.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; nibble index 0; carry register 0; operand latches cleared.
- FSM states:
  - IDLE: on start=1, latch a, b and mode; set carry register = mode; index = 0; busy <= 1; go to RUN.
  - RUN: each cycle processes nibble[index].
    - Slice inputs: a nibble, (b nibble XOR {4{mode}}), carry register.
    - Write the 4-bit sum into result bits [4*index+3 : 4*index] of the internal accumulator.
    - carry register <= slice carry out; index <= index + 1.
- Last nibble (index = NIBBLES-1), all on the same edge:
  - result <= full accumulator.
  - cout <= slice carry out.
  - overflow <= (carry into bit 3 of last nibble) XOR (carry out of bit 3).
  - done <= 1; busy <= 0; return to IDLE.
- Latency: start sampled at edge k → nibble i processed at edge k+1+i → done high during the cycle after edge k+NIBBLES. busy is high for exactly NIBBLES cycles.
- The slice is combinational inside this block; there is no extra pipeline stage.
- done is high for exactly one cycle, then 0.
- result, cout and overflow hold their values until the next done; they do not change during RUN.
- start while busy is ignored; a, b and mode may change freely during RUN with no effect.
- start high in the done cycle is accepted, because the FSM is already in IDLE. The next operation then begins back-to-back, with no idle gap required.
- rst during RUN: the operation is abandoned, no done pulse is produced, and all outputs and state return to their reset values on that edge.
- NIBBLES=1: RUN lasts one cycle; behaviour is identical to a registered 4-bit add/sub.

Optional Feature:
- Macro ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit), registered on the same edge as result.
  - zero = 1 when the final W-bit result is all zeros; otherwise 0.
  - Reset value 0; holds its value until the next done.
- Undefined:
  - Port zero and its logic are absent.
  - All other behaviour is unchanged.

Test Plan (NIBBLES=4):
1. mode=0, a=0x0000, b=0x0001, start pulsed at edge k → done only at cycle k+4; result=0x0001, cout=0, overflow=0; busy high for exactly 4 cycles.
2. mode=1, a=0x000A, b=0x0001 → result=0x0009, cout=1, overflow=0. Then mode=1, a=0x0000, b=0x0001 → result=0xFFFF, cout=0, overflow=0.
3. Carry ripple and overflow:
   - mode=0, a=0x7FFF, b=0x0001 → result=0x8000, cout=0, overflow=1.
   - mode=0, a=0xFFFF, b=0x0001 → result=0x0000, cout=1, overflow=0.
   - mode=1, a=0x8000, b=0x0001 → result=0x7FFF, cout=1, overflow=1.
4. Handshake:
   - Start an op with a=0x1111, b=0x2222, mode=0.
   - Pulse start with a=0xFFFF during RUN → ignored; result=0x3333.
   - Assert start with new operands (0x0003+0x0004) in the done cycle → second done exactly 4 cycles later with result=0x0007.
5. Reset mid-op: start 0x1234+0x1111, assert rst at the 2nd RUN cycle → busy=0, done never pulses, result/cout/overflow=0; a subsequent op completes normally.
6. With ZERO_FLAG_EN: mode=1, a=0x1234, b=0x1234 → result=0x0000, zero=1, cout=1. Next op 0x0001+0x0000 → zero=0 at done.
